mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the cache refill/write-through interface. It answers the cache controller's `mem_rd_en` / `mem_wd_en` requests from a word-addressed 64-bit backing store. Responses come back after fixed, parameterized latencies, as single-cycle `mem_data_valid` / `mem_wd_valid` pulses. It sits below the cache controller, serving as the main-memory model in simulation and as the memory-controller shell in the top-level design.

## Interface
- `MEM_AW`, 16: word-address width; store depth is 2**MEM_AW 64-bit words.
- `RD_LATENCY`, 4: cycles from read acceptance to `mem_data_valid`; legal range 1..255.
- `WR_LATENCY`, 2: cycles from write acceptance to `mem_wd_valid`; legal range 1..255.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_rd_en`  in  1  read request; held by the initiator until the response is seen.
- `mem_wd_en`  in  1  write request; held by the initiator until the ack is seen.
- `mem_addr`  in  32  byte address; word index is `mem_addr[3 +: MEM_AW]`; `[2:0]` is ignored.
- `mem_wd_data`  in  64  write data.
- `mem_data`  out  64  read data; registered and held until the next read response.
- `mem_data_valid`  out  1  one-cycle read-response pulse.
- `mem_wd_valid`  out  1  one-cycle write-ack pulse.
- `mem_busy`  out  1  high in every state except IDLE.
- `mem_err`  out  1  one-cycle out-of-range pulse; tied 0 unless `MEM_RESP_ADDR_CHECK_EN` is defined.

## Operation
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK, RELEASE.
- Transitions out of IDLE:
  - `mem_wd_en` sampled high: latch the address and `mem_wd_data`, load the counter with `WR_LATENCY-1`, go to WR_WAIT.
  - Otherwise `mem_rd_en` high: latch the address, load the counter with `RD_LATENCY-1`, go to RD_WAIT.
  - Both high: the write wins and the read is not serviced.
- RD_WAIT / WR_WAIT: decrement the counter; move to RD_RESP / WR_ACK when it reaches 0.
- RD_RESP: register the word at the latched index onto `mem_data`, assert `mem_data_valid` for one cycle, go to RELEASE.
- WR_ACK: commit the latched data to the latched index, assert `mem_wd_valid` for one cycle, go to RELEASE.
- RELEASE: stay until `mem_rd_en` and `mem_wd_en` are both low, then go to IDLE. A request held high after its response is therefore never serviced twice.
- Address and write data are latched at acceptance. Changes on the inputs after acceptance do not affect the transaction in flight.
- Storage is not reset. Contents survive `rst`; power-up contents are unspecified, and the bench initializes them by backdoor.

## Timing
- Read request sampled high in IDLE at edge k: `mem_data_valid` and the new `mem_data` are visible from edge k+RD_LATENCY+1 for exactly one cycle.
- Write accepted at edge k: `mem_wd_valid` is high after edge k+WR_LATENCY+1. A read of the same word issued after the ack returns the new data.
- Minimum request spacing is one RELEASE cycle plus one IDLE cycle.
- `rst` low at any time, including mid-transaction:
  - state goes to IDLE immediately;
  - `mem_data`=0, `mem_data_valid`=0, `mem_wd_valid`=0, `mem_busy`=0, `mem_err`=0;
  - a write still in WR_WAIT is dropped and not committed.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `MEM_RESP_ADDR_CHECK_EN` defined:
  - a request with any nonzero bit in `mem_addr[31:3+MEM_AW]` still follows normal timing;
  - a read returns `mem_data`=0, a write is not committed;
  - `mem_err` pulses in the same cycle as the valid pulse.
- Not defined: the upper address bits are ignored and the address wraps modulo the store depth. `mem_err` is constant 0.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum covering the six states;
  - `MEM_WORD_W`=64 and `MEM_ADDR_W`=32 constants;
  - `word_index()` function that extracts the word index.
- Sub-module `mem_word_array`: a 1R1W synchronous 64-bit storage array parameterized by `MEM_AW`, with write-enable, registered read, and no reset. The FSM, counter and latches stay in `mem_responder`.

## Test plan
- Backdoor word 5 = 0xDEAD_BEEF_0000_0005; `mem_rd_en` with `mem_addr`=0x28, RD_LATENCY=4: valid 5 edges after acceptance, `mem_data`=0xDEAD_BEEF_0000_0005, `mem_busy` high for 6 cycles.
- Write 0x1122_3344_5566_7788 to `mem_addr`=0x40, then read 0x40: write ack after WR_LATENCY+1 edges, read returns 0x1122_3344_5566_7788.
- Hold `mem_rd_en` high for 20 cycles after valid: exactly one `mem_data_valid` pulse; drop `mem_rd_en` and the FSM is back in IDLE 1 cycle later.
- `mem_rd_en` and `mem_wd_en` both high with `mem_addr`=0x80 and data 0xA5: only `mem_wd_valid` pulses, and word 16 = 0xA5.
- Assert `rst` during WR_WAIT of a write of 0xFF to word 3 (old value 0x0): all outputs go to 0 at once, and a later read of word 3 returns 0x0.
- With the macro defined and `mem_addr`=0x8000_0000: `mem_err` and `mem_data_valid` pulse together with `mem_data`=0. Without the macro, the same request reads word 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
package mem_pkg;

  localparam int unsigned MEM_WORD_W = 64;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_ACK  = 3'd4,
    ST_RELEASE = 3'd5
  } mem_state_t;

  // Byte address to full-width word index; callers truncate to their store depth.
  function automatic logic [MEM_ADDR_W-4:0] word_index(input logic [MEM_ADDR_W-1:0] addr);
    return (MEM_ADDR_W-3)'(addr >> 3);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// 1R1W synchronous 64-bit storage, registered read, contents not reset.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned MEM_AW = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [MEM_AW-1:0]     i_waddr,
  input  logic [MEM_WORD_W-1:0] i_wdata,
  input  logic [MEM_AW-1:0]     i_raddr,
  output logic [MEM_WORD_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  logic [MEM_WORD_W-1:0] r_mem [0:DEPTH-1];

  // Write port: commit on enable.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: one-cycle registered read of the addressed word.
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for cache refill / write-through requests.
// Fixed-latency read and write responses from a word-addressed 64-bit store.
// Optional macro MEM_RESP_ADDR_CHECK_EN: flag and suppress out-of-range
// accesses via mem_err instead of wrapping the address.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned WR_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd_en,
  input  logic                  mem_wd_en,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [MEM_WORD_W-1:0] mem_wd_data,
  output logic [MEM_WORD_W-1:0] mem_data,
  output logic                  mem_data_valid,
  output logic                  mem_wd_valid,
  output logic                  mem_busy,
  output logic                  mem_err
);

  localparam logic [MEM_CNT_W-1:0] RD_CNT_INIT = MEM_CNT_W'(RD_LATENCY - 1);
  localparam logic [MEM_CNT_W-1:0] WR_CNT_INIT = MEM_CNT_W'(WR_LATENCY - 1);

  mem_state_t            r_state;
  logic [MEM_CNT_W-1:0]  r_cnt;
  logic [MEM_AW-1:0]     r_addr;
  logic [MEM_WORD_W-1:0] r_wdata;
  logic                  r_oob;

  logic [MEM_AW-1:0]     w_idx;
  logic                  w_oob;
  logic                  w_we;
  logic [MEM_WORD_W-1:0] w_rd_data;

  // Word index wraps modulo the store depth.
  assign w_idx = MEM_AW'(word_index(mem_addr));

`ifdef MEM_RESP_ADDR_CHECK_EN
  // Any address bit above the store's reach marks the request out of range.
  assign w_oob = (mem_addr >> (3 + MEM_AW)) != '0;
`else
  assign w_oob = 1'b0;
`endif

  // Commit only in the ack state, so a write interrupted by reset never lands.
  assign w_we = (r_state == ST_WR_ACK) && !r_oob;

  mem_word_array #(
    .MEM_AW (MEM_AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rd_data)
  );

  // Request FSM, latency counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_oob          <= 1'b0;
      mem_data       <= '0;
      mem_data_valid <= 1'b0;
      mem_wd_valid   <= 1'b0;
      mem_busy       <= 1'b0;
    end else begin
      mem_data_valid <= 1'b0;
      mem_wd_valid   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_wd_en) begin
            r_addr   <= w_idx;
            r_wdata  <= mem_wd_data;
            r_oob    <= w_oob;
            r_cnt    <= WR_CNT_INIT;
            r_state  <= ST_WR_WAIT;
            mem_busy <= 1'b1;
          end else if (mem_rd_en) begin
            r_addr   <= w_idx;
            r_oob    <= w_oob;
            r_cnt    <= RD_CNT_INIT;
            r_state  <= ST_RD_WAIT;
            mem_busy <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RD_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RD_RESP: begin
          mem_data       <= r_oob ? '0 : w_rd_data;
          mem_data_valid <= 1'b1;
          r_state        <= ST_RELEASE;
        end
        ST_WR_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_WR_ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WR_ACK: begin
          mem_wd_valid <= 1'b1;
          r_state      <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Wait for the initiator to drop its request so it is served once.
          if (!mem_rd_en && !mem_wd_en) begin
            r_state  <= ST_IDLE;
            mem_busy <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_RESP_ADDR_CHECK_EN
  logic r_err;

  // Error pulse aligned with the read or write response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_oob && ((r_state == ST_RD_RESP) || (r_state == ST_WR_ACK));
    end
  end

  assign mem_err = r_err;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters).
module tb_mem_responder;

  localparam int unsigned MEM_AW     = 16;
  localparam int unsigned RD_LATENCY = 4;
  localparam int unsigned WR_LATENCY = 2;
  localparam int          TIMEOUT    = 50;

  logic        clk;
  logic        rst;
  logic        mem_rd_en;
  logic        mem_wd_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_wd_data;
  logic [63:0] mem_data;
  logic        mem_data_valid;
  logic        mem_wd_valid;
  logic        mem_busy;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(
    .MEM_AW     (MEM_AW),
    .RD_LATENCY (RD_LATENCY),
    .WR_LATENCY (WR_LATENCY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (mem_rd_en),
    .mem_wd_en      (mem_wd_en),
    .mem_addr       (mem_addr),
    .mem_wd_data    (mem_wd_data),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .mem_wd_valid   (mem_wd_valid),
    .mem_busy       (mem_busy),
    .mem_err        (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded loop is ever miswritten.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a read, wait for the response, drop the request and let the FSM release.
  task automatic do_read(input logic [31:0] a, output logic [63:0] d,
                         output logic e, output int lat);
    mem_addr  = a;
    mem_rd_en = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mem_data_valid && lat < TIMEOUT);
    d = mem_data;
    e = mem_err;
    mem_rd_en = 1'b0;
    tick();
  endtask

  // Issue a write, wait for the ack, drop the request and let the FSM release.
  task automatic do_write(input logic [31:0] a, input logic [63:0] wd, output int lat);
    mem_addr    = a;
    mem_wd_data = wd;
    mem_wd_en   = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mem_wd_valid && lat < TIMEOUT);
    mem_wd_en = 1'b0;
    tick();
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          busy_cnt;
    int          rd_pulses;
    int          wr_pulses;

    rst         = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wd_en   = 1'b0;
    mem_addr    = '0;
    mem_wd_data = '0;

    // Backdoor store initialisation.
    dut.u_array.r_mem[0]  = 64'h0123_4567_89AB_CDEF;
    dut.u_array.r_mem[3]  = 64'h0;
    dut.u_array.r_mem[5]  = 64'hDEAD_BEEF_0000_0005;
    dut.u_array.r_mem[8]  = 64'h0;
    dut.u_array.r_mem[16] = 64'h0;

    tick();
    tick();
    check("rst_data",  mem_data,       64'h0);
    check("rst_valid", mem_data_valid, 1'b0);
    check("rst_wdv",   mem_wd_valid,   1'b0);
    check("rst_busy",  mem_busy,       1'b0);
    check("rst_err",   mem_err,        1'b0);
    rst = 1'b1;
    tick();

    // Basic read of word 5: response RD_LATENCY+1 edges after acceptance.
    mem_addr  = 32'h28;
    mem_rd_en = 1'b1;
    lat = 0;
    busy_cnt = 0;
    do begin
      tick();
      lat++;
      if (mem_busy) busy_cnt++;
    end while (!mem_data_valid && lat < TIMEOUT);
    check("rd_latency", 64'(lat), 64'(RD_LATENCY + 2));
    check("rd_data",    mem_data, 64'hDEAD_BEEF_0000_0005);
    mem_rd_en = 1'b0;
    tick();
    if (mem_busy) busy_cnt++;
    check("rd_valid_one_cycle", mem_data_valid, 1'b0);
    check("rd_busy_after",      mem_busy,       1'b0);
    check("rd_busy_cycles",     64'(busy_cnt),  64'd6);
    check("rd_data_held",       mem_data,       64'hDEAD_BEEF_0000_0005);

    // Write then read back word 8.
    do_write(32'h40, 64'h1122_3344_5566_7788, lat);
    check("wr_latency",  64'(lat), 64'(WR_LATENCY + 2));
    check("wr_busy_after", mem_busy, 1'b0);
    check("wr_backdoor", dut.u_array.r_mem[8], 64'h1122_3344_5566_7788);
    do_read(32'h40, rd, er, lat);
    check("wr_readback", rd, 64'h1122_3344_5566_7788);

    // Low address bits are ignored.
    do_read(32'h2F, rd, er, lat);
    check("low_bits_ignored", rd, 64'hDEAD_BEEF_0000_0005);

    // Read held 20 cycles past the response: a single pulse.
    mem_addr  = 32'h28;
    mem_rd_en = 1'b1;
    rd_pulses = 0;
    for (int i = 0; i < int'(RD_LATENCY) + 2 + 20; i++) begin
      tick();
      if (mem_data_valid) rd_pulses++;
    end
    check("hold_pulses", 64'(rd_pulses), 64'd1);
    check("hold_busy",   mem_busy,       1'b1);
    mem_rd_en = 1'b0;
    tick();
    check("hold_idle", mem_busy, 1'b0);

    // Simultaneous read and write: write wins.
    mem_addr    = 32'h80;
    mem_wd_data = 64'hA5;
    mem_rd_en   = 1'b1;
    mem_wd_en   = 1'b1;
    rd_pulses = 0;
    wr_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_data_valid) rd_pulses++;
      if (mem_wd_valid)   wr_pulses++;
    end
    mem_rd_en = 1'b0;
    mem_wd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_data_valid) rd_pulses++;
      if (mem_wd_valid)   wr_pulses++;
    end
    check("both_wr_pulses", 64'(wr_pulses), 64'd1);
    check("both_rd_pulses", 64'(rd_pulses), 64'd0);
    check("both_word16",    dut.u_array.r_mem[16], 64'hA5);

    // Reset during WR_WAIT drops the write.
    mem_addr    = 32'h18;
    mem_wd_data = 64'hFF;
    mem_wd_en   = 1'b1;
    tick();
    check("mid_busy_before", mem_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_data",  mem_data,       64'h0);
    check("mid_rst_valid", mem_data_valid, 1'b0);
    check("mid_rst_wdv",   mem_wd_valid,   1'b0);
    check("mid_rst_busy",  mem_busy,       1'b0);
    check("mid_rst_err",   mem_err,        1'b0);
    mem_wd_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_word3_backdoor", dut.u_array.r_mem[3], 64'h0);
    do_read(32'h18, rd, er, lat);
    check("mid_word3_read", rd, 64'h0);
    check("mid_survivor", dut.u_array.r_mem[5], 64'hDEAD_BEEF_0000_0005);

    // Upper address bits set.
    do_read(32'h8000_0000, rd, er, lat);
    check("oob_latency", 64'(lat), 64'(RD_LATENCY + 2));
`ifdef MEM_RESP_ADDR_CHECK_EN
    check("oob_data", rd, 64'h0);
    check("oob_err",  er, 1'b1);
`else
    check("oob_data", rd, 64'h0123_4567_89AB_CDEF);
    check("oob_err",  er, 1'b0);
`endif
    check("oob_err_cleared", mem_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
